// File: rtl/biassram_r.sv
// biassram_r: bias SRAM reader; first read of entry 0, then serves entries 0..L-1 with wrap.
// Define BIAS_RD_PREFETCH_EN for the shadow-prefetch variant that sustains one request per cycle.
module biassram_r #(
  parameter int BIAS_ST_LENGTH = 64,
  parameter int ADDR_CNT_BITS  = 9,
  parameter int BIAS_SRAM_WLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bias_rd1st_start,
  output logic                      bias_rd1st_busy,
  output logic                      bias_rd1st_done,
  input  logic                      bias_req,
  input  logic                      layer_end,
  output logic                      bias_valid,
  output logic [BIAS_SRAM_WLEN-1:0] bias_data,
  output logic                      bias_last,
  output logic                      cen_biasr_0,
  output logic                      wen_biasr_0,
  output logic [ADDR_CNT_BITS-1:0]  addr_biasr_0,
  input  logic [BIAS_SRAM_WLEN-1:0] dout_biasr_0
);
  localparam logic [ADDR_CNT_BITS-1:0] LAST = ADDR_CNT_BITS'(BIAS_ST_LENGTH - 1);
  typedef enum logic [2:0] {IDLE, RD1, CAP, DONE1, SERVE, FETCH} state_t;
  state_t                    state_q, state_d;
  logic [ADDR_CNT_BITS-1:0]  ptr_q, ptr_d, idx_q, idx_d, ptr_nxt;
  logic [BIAS_SRAM_WLEN-1:0] data_q, data_d;
  logic                      valid_q, valid_d, take;
`ifdef BIAS_RD_PREFETCH_EN
  logic [BIAS_SRAM_WLEN-1:0] shadow_q, shadow_d;
  logic                      pf_q, pf_d;
`endif
  assign ptr_nxt = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign take = (state_q == SERVE) && !layer_end && bias_req && valid_q;
  assign wen_biasr_0 = 1'b1;
  assign bias_valid = valid_q;
  assign bias_data = data_q;
  assign bias_last = valid_q && (idx_q == LAST);
  assign bias_rd1st_busy = (state_q == RD1) || (state_q == CAP) || (state_q == DONE1);
  assign bias_rd1st_done = (state_q == DONE1);
`ifdef BIAS_RD_PREFETCH_EN
  // The next word is always read one step ahead so a request never waits on the SRAM.
  assign cen_biasr_0 = !((state_q == RD1) || (state_q == DONE1) || take);
  assign addr_biasr_0 = (state_q == RD1) ? '0 : take ? ptr_nxt : ptr_q;
`else
  assign cen_biasr_0 = !((state_q == RD1) || take);
  assign addr_biasr_0 = (state_q == RD1) ? '0 : ptr_q;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    data_d = data_q;
    valid_d = valid_q;
`ifdef BIAS_RD_PREFETCH_EN
    pf_d = (state_q == DONE1) || take;
    shadow_d = pf_q ? dout_biasr_0 : shadow_q;
`endif
    case (state_q)
      IDLE: state_d = bias_rd1st_start ? RD1 : IDLE;
      RD1: begin
        ptr_d = ADDR_CNT_BITS'(1);
        state_d = CAP;
      end
      CAP: begin
        data_d = dout_biasr_0;
        idx_d = '0;
        valid_d = 1'b1;
        state_d = DONE1;
      end
      DONE1: state_d = SERVE;
      SERVE: begin
        if (layer_end) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (take) begin
          idx_d = ptr_q;
          ptr_d = ptr_nxt;
`ifdef BIAS_RD_PREFETCH_EN
          data_d = pf_q ? dout_biasr_0 : shadow_q;
`else
          valid_d = 1'b0;
          state_d = FETCH;
`endif
        end
      end
      FETCH: begin
        data_d = dout_biasr_0;
        valid_d = 1'b1;
        state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
`ifdef BIAS_RD_PREFETCH_EN
      shadow_q <= '0;
      pf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
`ifdef BIAS_RD_PREFETCH_EN
      shadow_q <= shadow_d;
      pf_q <= pf_d;
`endif
    end
  end
endmodule

// File: tb/tb_biassram_r.sv
// tb_biassram_r: directed self-checking bench for biassram_r with L=4 and SRAM[i]=0x100+i.
module tb_biassram_r;
  logic        clk = 1'b0;
  logic        reset, start, req, layer_end;
  logic        busy, done, valid, last, cen, wen;
  logic [31:0] data, dout;
  logic [8:0]  addr;
  int          n_chk = 0;
  int          n_fail = 0;

  biassram_r #(.BIAS_ST_LENGTH(4), .ADDR_CNT_BITS(9), .BIAS_SRAM_WLEN(32)) dut (
    .clk(clk), .reset(reset), .bias_rd1st_start(start), .bias_rd1st_busy(busy),
    .bias_rd1st_done(done), .bias_req(req), .layer_end(layer_end), .bias_valid(valid),
    .bias_data(data), .bias_last(last), .cen_biasr_0(cen), .wen_biasr_0(wen),
    .addr_biasr_0(addr), .dout_biasr_0(dout)
  );

  always #5 clk = ~clk;

  // SRAM model: data only meaningful in the cycle after a read, junk otherwise.
  always @(posedge clk) dout <= cen ? 32'hDEAD_BEEF : 32'h100 + {23'b0, addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; req = 1'b0; layer_end = 1'b0;
    tick(); tick();
    #1;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_cen", {31'b0, cen}, 32'd1);
    chk("rst_wen", {31'b0, wen}, 32'd1);
    reset = 1'b1;
    // first read: start in cycle t
    tick(); start = 1'b1; #1;
    chk("t0_busy", {31'b0, busy}, 32'd0);
    tick(); start = 1'b0; #1;
    chk("t1_cen", {31'b0, cen}, 32'd0);
    chk("t1_addr", {23'b0, addr}, 32'd0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_done", {31'b0, done}, 32'd0);
    tick(); start = 1'b1; #1;
    chk("t2_busy", {31'b0, busy}, 32'd1);
    chk("t2_done", {31'b0, done}, 32'd0);
    chk("t2_valid", {31'b0, valid}, 32'd0);
    tick(); start = 1'b0; #1;
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_busy", {31'b0, busy}, 32'd1);
    chk("t3_valid", {31'b0, valid}, 32'd1);
    chk("t3_data", data, 32'h100);
    chk("t3_last", {31'b0, last}, 32'd0);
    tick(); #1;
    chk("t4_done", {31'b0, done}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_valid", {31'b0, valid}, 32'd1);
    chk("t4_data", data, 32'h100);
`ifdef BIAS_RD_PREFETCH_EN
    req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) req = 1'b0;
      #1;
      chk("pf_valid", {31'b0, valid}, 32'd1);
      chk("pf_data", data, 32'h100 + 32'(k % 4));
      chk("pf_last", {31'b0, last}, (k % 4 == 3) ? 32'd1 : 32'd0);
    end
`else
    for (int k = 1; k <= 3; k++) begin
      req = 1'b1; #1;
      chk("req_cen", {31'b0, cen}, 32'd0);
      chk("req_addr", {23'b0, addr}, 32'(k));
      tick(); req = 1'b0; #1;
      chk("bubble_valid", {31'b0, valid}, 32'd0);
      chk("bubble_cen", {31'b0, cen}, 32'd1);
      tick(); #1;
      chk("srv_valid", {31'b0, valid}, 32'd1);
      chk("srv_data", data, 32'h100 + 32'(k));
      chk("srv_last", {31'b0, last}, (k == 3) ? 32'd1 : 32'd0);
      chk("srv_done", {31'b0, done}, 32'd0);
    end
    req = 1'b1; #1;
    chk("wrap_addr", {23'b0, addr}, 32'd0);
    chk("wrap_cen", {31'b0, cen}, 32'd0);
    tick(); req = 1'b0;
    tick(); #1;
    chk("wrap_data", data, 32'h100);
    chk("wrap_last", {31'b0, last}, 32'd0);
    chk("wrap_valid", {31'b0, valid}, 32'd1);
`endif
    // request and layer_end together: layer_end wins, no read
    req = 1'b1; layer_end = 1'b1; #1;
    chk("le_cen", {31'b0, cen}, 32'd1);
    tick(); layer_end = 1'b0; #1;
    chk("le_valid", {31'b0, valid}, 32'd0);
    chk("le_busy", {31'b0, busy}, 32'd0);
    chk("idle_req_cen", {31'b0, cen}, 32'd1);
    tick(); req = 1'b0; #1;
    chk("idle_valid", {31'b0, valid}, 32'd0);
    // restart, then reset right after a request
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); #1;
    chk("rs_done", {31'b0, done}, 32'd1);
    chk("rs_data", data, 32'h100);
    tick(); req = 1'b1;
    tick(); req = 1'b0; reset = 1'b0;
    tick(); reset = 1'b1; #1;
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_data", data, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk("mid_rst_nodone", {31'b0, done}, 32'd0);
    end
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); #1;
    chk("re_done", {31'b0, done}, 32'd1);
    chk("re_valid", {31'b0, valid}, 32'd1);
    chk("re_data", data, 32'h100);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
